magenta_control_fsm: RTL and testbench
======================================

// Module: magenta_control_fsm
// PURPOSE
//  Multicycle Moore control FSM that sequences the magenta ALU stage: drives ALUSrcA/B, ALUOp and Branch selects.
//  Also sequences PC, IR, accumulator, SP and memory strobes per instruction.
//  Sits beside the ALU stage; consumes opcode from IR and ShouldBranch from ALU; stalls on memory handshake.
// PARAMETERS
//  MAX_WAIT     8        max cycles held in a memory state awaiting MemReadyIn; 0 = wait forever
//  HALT_OPCODE  5'b11111 opcode that enters HALT
// PORTS
//  CLK            in  1  clock, rising edge
//  ResetN         in  1  asynchronous active-low reset
//  OpcodeIn       in  5  IR[15:11], valid from DECODE onward
//  ShouldBranchIn in  1  ALU compare result, combinational, valid in BRANCH
//  MemReadyIn     in  1  memory completes access this cycle
//  ALUSrcA        out 2  00 PC, 01 ALUOut, 10 RegA, 11 SP
//  ALUSrcB        out 2  00 RegB, 01 Imm, 10 MDR, 11 const 2
//  ALUOp          out 2  00 add, 01 compare, 10 opcode-defined
//  Branch         out 2  PC source: 00 ALU wire, 01 ALUOut reg, 10 MDR
//  PCWrite        out 1  PC <= BranchOut
//  IRWrite        out 1  IR <= memory data
//  AccWrite       out 1  accumulator write
//  MemToAcc       out 1  acc source: 1 MDR, 0 ALUOut
//  SPWrite        out 1  SP <= ALU result wire
//  MemRead        out 1  memory read strobe
//  MemWrite       out 1  memory write strobe
//  IorD           out 2  address: 00 PC, 01 ALUOut, 10 SP
//  BusErrOut      out 1  sticky: MAX_WAIT expired
//  HaltedOut      out 1  high in HALT/TRAP
//  StateOut       out 4  current state code, debug
// BEHAVIOUR
//  States: INIT0 FETCH1 DECODE2 EXEC_ALU3 WB_ACC4 ADDR5 MEM_RD6 WB_MEM7 MEM_WR8 BRANCH9 JUMP10 STACK_RD11 RET12 HALT13 TRAP14.
//  Reset: state=INIT, all outputs 0, wait counter 0, BusErrOut 0; INIT lasts one cycle -> FETCH.
//  Unlisted selects are 00 and unlisted strobes are 0 in every state.
//  FETCH: MemRead, IorD=00, SrcA=00, SrcB=11, ALUOp=00, Branch=00.
//   IRWrite and PCWrite are asserted only in the cycle MemReadyIn=1 (PC<=PC+2), then -> DECODE; otherwise hold.
//  DECODE: SrcA=00, SrcB=01, ALUOp=00 (ALUOut<=PC+imm, the branch target). Dispatch on OpcodeIn:
//   00xxx -> EXEC_ALU (SrcA=10, SrcB=00, ALUOp=10) -> WB_ACC (AccWrite, MemToAcc=0) -> FETCH.
//   01xxx -> EXEC_ALU with SrcB=01 -> WB_ACC -> FETCH.
//   10000 lw, 10001 sw -> ADDR (SrcA=10, SrcB=01, ALUOp=00).
//    lw: -> MEM_RD (MemRead, IorD=01) -> WB_MEM (AccWrite, MemToAcc=1) -> FETCH.
//    sw: -> MEM_WR (MemWrite, IorD=01) -> FETCH.
//   10010/10011 beq/bne -> BRANCH: SrcA=10, SrcB=00, ALUOp=01, Branch=01; PCWrite=ShouldBranchIn; -> FETCH.
//   10100 j -> JUMP: Branch=01, PCWrite -> FETCH.
//   10101 ret -> STACK_RD (MemRead, IorD=10) -> RET (Branch=10, PCWrite, SrcA=11, SrcB=11, ALUOp=00, SPWrite) -> FETCH.
//   HALT_OPCODE -> HALT. Any other opcode = illegal (see CONFIGURATION).
//  Memory states FETCH, MEM_RD, MEM_WR, STACK_RD:
//   Advance only on MemReadyIn=1; strobes stay high while waiting.
//   Wait counter clears on state entry and increments each stalled cycle.
//   If MAX_WAIT != 0 and counter reaches MAX_WAIT with MemReadyIn=0: BusErrOut<=1, -> HALT.
//   MemReadyIn=1 in the same cycle the limit is reached wins: normal advance, no error.
//  HALT/TRAP: all strobes 0, HaltedOut=1, held until ResetN low.
//  ResetN asserted mid-instruction: immediate return to INIT; no strobe is asserted after the asynchronous edge.
//  Latency: ALU 4 cycles, lw 5, sw 4, branch/jump 3, ret 4 (each memory state +1 per stall cycle).
// CONFIGURATION
//  MAGENTA_CTRL_ILLEGAL_TRAP_EN defined: illegal opcode DECODE -> TRAP, HaltedOut=1, StateOut=14.
//  MAGENTA_CTRL_ILLEGAL_TRAP_EN undefined: illegal opcode executes as NOP, DECODE -> FETCH; TRAP state is unreachable.
// TESTING
//  Reset release, MemReadyIn=1 -> INIT 1 cycle; FETCH shows MemRead=1, SrcB=11, PCWrite=1, IRWrite=1.
//  Opcode 00011, MemReadyIn=1 -> states 1,2,3,4,1; AccWrite=1 only in state 4 with MemToAcc=0.
//  lw 10000, MemReadyIn low 3 cycles in MEM_RD -> MemRead held 4 cycles; WB_MEM asserts AccWrite, MemToAcc=1.
//  beq 10010: ShouldBranchIn=1 -> PCWrite=1 and Branch=01 in BRANCH; ShouldBranchIn=0 -> PCWrite=0; both -> FETCH.
//  MAX_WAIT=8, MemReadyIn stuck 0 in FETCH -> after 8 stalled cycles BusErrOut=1, StateOut=13; ResetN pulse clears both.
//  Opcode 11000 -> TRAP (14) with MAGENTA_CTRL_ILLEGAL_TRAP_EN defined, FETCH (1) without.

Source files
------------

// File: rtl/magenta_control_fsm.sv
// Multicycle Moore control FSM for the magenta ALU stage: drives datapath selects, register strobes and memory strobes.
// Optional feature: define MAGENTA_CTRL_ILLEGAL_TRAP_EN to send illegal opcodes to TRAP instead of executing them as NOPs.
`timescale 1ns/1ps

module magenta_control_fsm #(
    parameter int         MAX_WAIT    = 8,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic       CLK,
    input  logic       ResetN,
    input  logic [4:0] OpcodeIn,
    input  logic       ShouldBranchIn,
    input  logic       MemReadyIn,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] Branch,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AccWrite,
    output logic       MemToAcc,
    output logic       SPWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] IorD,
    output logic       BusErrOut,
    output logic       HaltedOut,
    output logic [3:0] StateOut
);

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_ALU = 4'd3,
        WB_ACC   = 4'd4,
        ADDR     = 4'd5,
        MEM_RD   = 4'd6,
        WB_MEM   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        STACK_RD = 4'd11,
        RET      = 4'd12,
        HALT     = 4'd13,
        TRAP     = 4'd14
    } stateT;

    localparam int CountW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // The timeout fires on the MAX_WAIT-th stalled cycle, so compare against one less than the limit.
    localparam logic [CountW-1:0] LastWait = (MAX_WAIT == 0) ? '0 : CountW'(MAX_WAIT - 1);

    stateT             state;
    stateT             nextState;
    logic [CountW-1:0] waitCount;
    logic              busErr;
    logic              isMemState;
    logic              timeoutHit;

    assign isMemState = (state == FETCH) || (state == MEM_RD) ||
                        (state == MEM_WR) || (state == STACK_RD);
    assign timeoutHit = (MAX_WAIT != 0) && isMemState && !MemReadyIn && (waitCount == LastWait);

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state     <= INIT;
            waitCount <= '0;
            busErr    <= 1'b0;
        end else begin
            state <= nextState;
            if (nextState != state) begin
                waitCount <= '0;
            end else if (isMemState && !MemReadyIn && (waitCount != '1)) begin
                waitCount <= waitCount + CountW'(1);
            end
            if (timeoutHit) begin
                busErr <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT:     nextState = FETCH;
            FETCH: begin
                if (timeoutHit)      nextState = HALT;
                else if (MemReadyIn) nextState = DECODE;
            end
            DECODE: begin
                if (OpcodeIn == HALT_OPCODE) begin
                    nextState = HALT;
                end else begin
                    casez (OpcodeIn)
                        5'b00???, 5'b01???: nextState = EXEC_ALU;
                        5'b10000, 5'b10001: nextState = ADDR;
                        5'b10010, 5'b10011: nextState = BRANCH;
                        5'b10100:           nextState = JUMP;
                        5'b10101:           nextState = STACK_RD;
                        default: begin
`ifdef MAGENTA_CTRL_ILLEGAL_TRAP_EN
                            nextState = TRAP;
`else
                            nextState = FETCH;
`endif
                        end
                    endcase
                end
            end
            EXEC_ALU: nextState = WB_ACC;
            WB_ACC:   nextState = FETCH;
            // Only lw/sw reach ADDR; bit 0 of the opcode tells them apart.
            ADDR:     nextState = OpcodeIn[0] ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (timeoutHit)      nextState = HALT;
                else if (MemReadyIn) nextState = WB_MEM;
            end
            WB_MEM:   nextState = FETCH;
            MEM_WR: begin
                if (timeoutHit)      nextState = HALT;
                else if (MemReadyIn) nextState = FETCH;
            end
            BRANCH:   nextState = FETCH;
            JUMP:     nextState = FETCH;
            STACK_RD: begin
                if (timeoutHit)      nextState = HALT;
                else if (MemReadyIn) nextState = RET;
            end
            RET:      nextState = FETCH;
            HALT:     nextState = HALT;
            TRAP:     nextState = TRAP;
            default:  nextState = INIT;
        endcase
    end

    // Outputs depend only on the registered state (plus the ready/compare qualifiers), so reset silences them at once.
    always_comb begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Branch    = 2'b00;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AccWrite  = 1'b0;
        MemToAcc  = 1'b0;
        SPWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 2'b00;
        HaltedOut = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b11;
                PCWrite = MemReadyIn;
                IRWrite = MemReadyIn;
            end
            DECODE: begin
                ALUSrcB = 2'b01;
            end
            EXEC_ALU: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                ALUSrcB = (OpcodeIn[4:3] == 2'b01) ? 2'b01 : 2'b00;
            end
            WB_ACC: begin
                AccWrite = 1'b1;
            end
            ADDR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 2'b01;
            end
            WB_MEM: begin
                AccWrite = 1'b1;
                MemToAcc = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 2'b01;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 2'b01;
                PCWrite = ShouldBranchIn;
            end
            JUMP: begin
                Branch  = 2'b01;
                PCWrite = 1'b1;
            end
            STACK_RD: begin
                MemRead = 1'b1;
                IorD    = 2'b10;
            end
            RET: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b11;
                Branch  = 2'b10;
                PCWrite = 1'b1;
                SPWrite = 1'b1;
            end
            HALT, TRAP: begin
                HaltedOut = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign BusErrOut = busErr;
    assign StateOut  = state;

endmodule

// File: tb/tb_magenta_control_fsm.sv
// Self-checking bench for magenta_control_fsm: literal vector table, hand-written corner sequences,
// and randomized instruction streams checked against a per-instruction path model.
`timescale 1ns/1ps

module tb_magenta_control_fsm;

    logic       CLK = 1'b0;
    logic       ResetN = 1'b0;
    logic [4:0] OpcodeIn = 5'd0;
    logic       ShouldBranchIn = 1'b0;
    logic       MemReadyIn = 1'b0;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, Branch, IorD;
    logic       PCWrite, IRWrite, AccWrite, MemToAcc, SPWrite, MemRead, MemWrite;
    logic       BusErrOut, HaltedOut;
    logic [3:0] StateOut;

    int checks = 0;
    int errors = 0;

    localparam logic [22:0] ZERO = '0;

    magenta_control_fsm dut (
        .CLK(CLK), .ResetN(ResetN), .OpcodeIn(OpcodeIn), .ShouldBranchIn(ShouldBranchIn),
        .MemReadyIn(MemReadyIn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Branch(Branch), .PCWrite(PCWrite), .IRWrite(IRWrite), .AccWrite(AccWrite),
        .MemToAcc(MemToAcc), .SPWrite(SPWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .BusErrOut(BusErrOut), .HaltedOut(HaltedOut), .StateOut(StateOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test completed");
        $fatal(1, "[TB] watchdog");
    end

    // Packed view: {srcA, srcB, aluOp, branch, {pcW,irW,accW,m2a,spW,memRd,memWr}, iorD, busErr, halted, state}
    function automatic logic [22:0] packOut(logic [1:0] a, logic [1:0] b, logic [1:0] alu, logic [1:0] br,
                                            logic [6:0] stb, logic [1:0] iord, logic be, logic h,
                                            logic [3:0] st);
        return {a, b, alu, br, stb, iord, be, h, st};
    endfunction

    function automatic logic [22:0] dutOut();
        return packOut(ALUSrcA, ALUSrcB, ALUOp, Branch,
                       {PCWrite, IRWrite, AccWrite, MemToAcc, SPWrite, MemRead, MemWrite},
                       IorD, BusErrOut, HaltedOut, StateOut);
    endfunction

    // Output rules per state as listed in the control table of the block description.
    function automatic logic [22:0] modelOut(logic [3:0] st, logic [4:0] op, logic rdy, logic sb, logic be);
        logic [1:0] a = 2'b00, b = 2'b00, alu = 2'b00, br = 2'b00, iord = 2'b00;
        logic pcW = 1'b0, irW = 1'b0, accW = 1'b0, m2a = 1'b0, spW = 1'b0, mr = 1'b0, mw = 1'b0, h = 1'b0;
        case (st)
            4'd1:  begin mr = 1'b1; b = 2'b11; pcW = rdy; irW = rdy; end
            4'd2:  b = 2'b01;
            4'd3:  begin a = 2'b10; alu = 2'b10; b = (op[4:3] == 2'b01) ? 2'b01 : 2'b00; end
            4'd4:  accW = 1'b1;
            4'd5:  begin a = 2'b10; b = 2'b01; end
            4'd6:  begin mr = 1'b1; iord = 2'b01; end
            4'd7:  begin accW = 1'b1; m2a = 1'b1; end
            4'd8:  begin mw = 1'b1; iord = 2'b01; end
            4'd9:  begin a = 2'b10; alu = 2'b01; br = 2'b01; pcW = sb; end
            4'd10: begin br = 2'b01; pcW = 1'b1; end
            4'd11: begin mr = 1'b1; iord = 2'b10; end
            4'd12: begin a = 2'b11; b = 2'b11; br = 2'b10; pcW = 1'b1; spW = 1'b1; end
            4'd13, 4'd14: h = 1'b1;
            default: ;
        endcase
        return packOut(a, b, alu, br, {pcW, irW, accW, m2a, spW, mr, mw}, iord, be, h, st);
    endfunction

    task automatic checkOutput(string name, logic [22:0] expected);
        logic [22:0] actual;
        actual = dutOut();
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(logic [4:0] op, logic rdy, logic sb);
        @(negedge CLK);
        OpcodeIn       = op;
        MemReadyIn     = rdy;
        ShouldBranchIn = sb;
        #1;
    endtask

    task automatic stepModel(string name, logic [4:0] op, logic rdy, logic sb, logic [3:0] st, logic be);
        applyStimulus(op, rdy, sb);
        checkOutput(name, modelOut(st, op, rdy, sb, be));
    endtask

    task automatic doReset();
        ResetN = 1'b0;
        MemReadyIn = 1'b1;
        ShouldBranchIn = 1'b0;
        OpcodeIn = 5'd0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("reset", ZERO);
        ResetN = 1'b1;
        #1;
        checkOutput("init", ZERO);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        rdy;
        logic        sb;
        logic [22:0] exp;
    } vecT;

    vecT vecs[$];

    task automatic addVec(logic [4:0] op, logic rdy, logic sb, logic [3:0] st, logic [1:0] a,
                          logic [1:0] b, logic [1:0] alu, logic [1:0] br, logic [6:0] stb,
                          logic [1:0] iord);
        vecT v;
        v.op = op; v.rdy = rdy; v.sb = sb;
        v.exp = packOut(a, b, alu, br, stb, iord, 1'b0, 1'b0, st);
        vecs.push_back(v);
    endtask

    logic [3:0] path[$];

    // Sequence of states an instruction walks through, taken from the instruction descriptions.
    task automatic buildPath(logic [4:0] op);
        path = {};
        path.push_back(4'd1);
        path.push_back(4'd2);
        if (op[4] == 1'b0) begin
            path.push_back(4'd3); path.push_back(4'd4);
        end else if (op == 5'b10000) begin
            path.push_back(4'd5); path.push_back(4'd6); path.push_back(4'd7);
        end else if (op == 5'b10001) begin
            path.push_back(4'd5); path.push_back(4'd8);
        end else if (op == 5'b10010 || op == 5'b10011) begin
            path.push_back(4'd9);
        end else if (op == 5'b10100) begin
            path.push_back(4'd10);
        end else if (op == 5'b10101) begin
            path.push_back(4'd11); path.push_back(4'd12);
        end
    endtask

    initial begin
        logic [4:0] op;
        logic [3:0] st;
        logic       rdy;
        int         stalls;

        // Strobe column order: {PCWrite, IRWrite, AccWrite, MemToAcc, SPWrite, MemRead, MemWrite}
        addVec(5'b00000, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b00011, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b00011, 1'b1, 1'b0, 4'd3,  2'b10, 2'b00, 2'b10, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b00011, 1'b1, 1'b0, 4'd4,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0010000, 2'b00);
        addVec(5'b00011, 1'b0, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b0000010, 2'b00);
        addVec(5'b00011, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b01010, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b01010, 1'b1, 1'b0, 4'd3,  2'b10, 2'b01, 2'b10, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b01010, 1'b1, 1'b0, 4'd4,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0010000, 2'b00);
        addVec(5'b01010, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b10010, 1'b1, 1'b1, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10010, 1'b0, 1'b1, 4'd9,  2'b10, 2'b00, 2'b01, 2'b01, 7'b1000000, 2'b00);
        addVec(5'b10010, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b10011, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10011, 1'b1, 1'b0, 4'd9,  2'b10, 2'b00, 2'b01, 2'b01, 7'b0000000, 2'b00);
        addVec(5'b10011, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b10100, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10100, 1'b0, 1'b0, 4'd10, 2'b00, 2'b00, 2'b00, 2'b01, 7'b1000000, 2'b00);
        addVec(5'b10100, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b10001, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10001, 1'b1, 1'b0, 4'd5,  2'b10, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10001, 1'b0, 1'b0, 4'd8,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0000001, 2'b01);
        addVec(5'b10001, 1'b1, 1'b0, 4'd8,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0000001, 2'b01);
        addVec(5'b10001, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);
        addVec(5'b10101, 1'b1, 1'b0, 4'd2,  2'b00, 2'b01, 2'b00, 2'b00, 7'b0000000, 2'b00);
        addVec(5'b10101, 1'b0, 1'b0, 4'd11, 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000010, 2'b10);
        addVec(5'b10101, 1'b1, 1'b0, 4'd11, 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000010, 2'b10);
        addVec(5'b10101, 1'b0, 1'b0, 4'd12, 2'b11, 2'b11, 2'b00, 2'b10, 7'b1000100, 2'b00);
        addVec(5'b10101, 1'b1, 1'b0, 4'd1,  2'b00, 2'b11, 2'b00, 2'b00, 7'b1100010, 2'b00);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].rdy, vecs[i].sb);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // lw with three stall cycles in MEM_RD, then an asynchronous reset in the middle of a second lw.
        doReset();
        stepModel("lwFetch", 5'b10000, 1'b1, 1'b0, 4'd1, 1'b0);
        stepModel("lwDecode", 5'b10000, 1'b1, 1'b0, 4'd2, 1'b0);
        stepModel("lwAddr", 5'b10000, 1'b1, 1'b0, 4'd5, 1'b0);
        for (int k = 0; k < 3; k++) stepModel($sformatf("lwStall%0d", k), 5'b10000, 1'b0, 1'b0, 4'd6, 1'b0);
        stepModel("lwReady", 5'b10000, 1'b1, 1'b0, 4'd6, 1'b0);
        stepModel("lwWbMem", 5'b10000, 1'b0, 1'b0, 4'd7, 1'b0);
        stepModel("lwNextFetch", 5'b10000, 1'b1, 1'b0, 4'd1, 1'b0);
        stepModel("lw2Decode", 5'b10000, 1'b1, 1'b0, 4'd2, 1'b0);
        stepModel("lw2Addr", 5'b10000, 1'b1, 1'b0, 4'd5, 1'b0);
        stepModel("lw2MemRd", 5'b10000, 1'b0, 1'b0, 4'd6, 1'b0);
        #2 ResetN = 1'b0;
        #1 checkOutput("midReset", ZERO);

        // Stuck memory in FETCH: eight stalled cycles, then HALT with the sticky bus error.
        doReset();
        for (int k = 0; k < 8; k++) stepModel($sformatf("fetchStall%0d", k), 5'b00000, 1'b0, 1'b0, 4'd1, 1'b0);
        stepModel("timeoutHalt", 5'b00000, 1'b1, 1'b0, 4'd13, 1'b1);
        stepModel("timeoutHold", 5'b00000, 1'b1, 1'b1, 4'd13, 1'b1);
        ResetN = 1'b0;
        #1 checkOutput("busErrClear", ZERO);

        // HALT opcode parks the FSM regardless of inputs.
        doReset();
        stepModel("haltFetch", 5'b11111, 1'b1, 1'b0, 4'd1, 1'b0);
        stepModel("haltDecode", 5'b11111, 1'b1, 1'b0, 4'd2, 1'b0);
        for (int k = 0; k < 3; k++) stepModel($sformatf("haltHold%0d", k), 5'b00000, 1'b1, 1'b1, 4'd13, 1'b0);

        // Illegal opcode behaviour depends on the trap build option.
        doReset();
        stepModel("illegalFetch", 5'b11000, 1'b1, 1'b0, 4'd1, 1'b0);
        stepModel("illegalDecode", 5'b11000, 1'b1, 1'b0, 4'd2, 1'b0);
`ifdef MAGENTA_CTRL_ILLEGAL_TRAP_EN
        stepModel("illegalTrap", 5'b11000, 1'b1, 1'b0, 4'd14, 1'b0);
        stepModel("illegalTrapHold", 5'b00000, 1'b1, 1'b0, 4'd14, 1'b0);
`else
        stepModel("illegalNop", 5'b11000, 1'b0, 1'b0, 4'd1, 1'b0);
`endif

        // Random instruction stream; memory stalls up to 7 cycles exercise the ready-wins boundary.
        doReset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       op = {1'b0, 4'($urandom)};
                1:       op = 5'b10000;
                2:       op = 5'b10001;
                3:       op = {4'b1001, 1'($urandom)};
                4:       op = 5'b10100;
                default: op = 5'b10101;
            endcase
            buildPath(op);
            for (int p = 0; p < path.size(); p++) begin
                st = path[p];
                if (st == 4'd1 || st == 4'd6 || st == 4'd8 || st == 4'd11)
                    stalls = ($urandom_range(0, 4) == 0) ? 7 : int'($urandom_range(0, 3));
                else
                    stalls = 0;
                for (int k = 0; k <= stalls; k++) begin
                    if (st == 4'd1 || st == 4'd6 || st == 4'd8 || st == 4'd11)
                        rdy = (k == stalls);
                    else
                        rdy = 1'($urandom);
                    stepModel($sformatf("rand%0d_st%0d", n, st), (st == 4'd1) ? 5'($urandom) : op,
                              rdy, 1'($urandom), st, 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
